// File: rtl/hp_rom_pkg.sv
// Shared word geometry, select-ROM opcode and ROM address layout for the serial-ROM sequencer.
package hp_rom_pkg;

    localparam int DEF_WORD_BITS  = 56;
    localparam int DEF_SYNC_BITS  = 10;
    localparam int DEF_SYNC_START = 44;
    localparam int DEF_ADDR_BITS  = 8;
    localparam int DEF_ADDR_START = 19;
    localparam int DEF_NROMS      = 8;
    localparam int DEF_ROM_BITS   = $clog2(DEF_NROMS);

    localparam logic [6:0] SEL_ROM_OP = 7'b0010000;

    // {active ROM, word address} as presented to the ROM array (default geometry)
    typedef struct packed {
        logic [DEF_ROM_BITS-1:0]  rom;
        logic [DEF_ADDR_BITS-1:0] addr;
    } rom_addr_t;

    function automatic logic is_sel_rom(input logic [6:0] op);
        return op == SEL_ROM_OP;
    endfunction

endpackage

// File: rtl/hp_bit_timer.sv
// Bit-time counter with sync rising-edge resync and optional phase-lock / error tracking.
// Lock checking is compiled in with HP_ROM_SEQ_CTRL_SYNC_CHECK_EN.
module hp_bit_timer import hp_rom_pkg::*; #(
    parameter int WORD_BITS  = DEF_WORD_BITS,
    parameter int SYNC_START = DEF_SYNC_START
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_sync,
    output logic [$clog2(WORD_BITS)-1:0] o_bit_cnt,
    output logic                         o_edge,
    output logic                         o_locked,
    output logic                         o_lock_nxt,
    output logic                         o_sync_err
);

    localparam int CNT_W = $clog2(WORD_BITS);

    logic             r_sync_d;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             w_edge;

    assign w_edge    = i_sync & ~r_sync_d;
    assign o_edge    = w_edge;
    assign o_bit_cnt = r_bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_d  <= 1'b0;
            r_bit_cnt <= '0;
        end else begin
            r_sync_d <= i_sync;
            if (w_edge) begin
                r_bit_cnt <= CNT_W'(SYNC_START + 1);
            end else if (r_bit_cnt == CNT_W'(WORD_BITS - 1)) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

`ifdef HP_ROM_SEQ_CTRL_SYNC_CHECK_EN
    logic       w_on_time;
    logic [1:0] r_good;
    logic [1:0] w_good_nxt;
    logic       w_lock_nxt;
    logic       r_locked;
    logic       r_sync_err;

    assign w_on_time = (r_bit_cnt == CNT_W'(SYNC_START));

    // Saturating count of consecutive on-time edges; two of them means locked.
    always_comb begin
        w_good_nxt = r_good;
        if (w_edge) begin
            if (!w_on_time) begin
                w_good_nxt = 2'd0;
            end else if (r_good != 2'd2) begin
                w_good_nxt = r_good + 2'd1;
            end
        end
    end

    assign w_lock_nxt = (w_good_nxt == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_good     <= 2'd0;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_good     <= w_good_nxt;
            r_locked   <= w_lock_nxt;
            r_sync_err <= w_edge & ~w_on_time;
        end
    end

    assign o_locked   = r_locked;
    assign o_lock_nxt = w_lock_nxt;
    assign o_sync_err = r_sync_err;
`else
    assign o_locked   = 1'b1;
    assign o_lock_nxt = 1'b1;
    assign o_sync_err = 1'b0;
`endif

endmodule

// File: rtl/hp_rom_seq_ctrl.sv
// Serial-ROM sequencer: serial address capture, parallel ROM fetch, serial instruction emit, ROM bank select.
// Optional sync lock/error checking via HP_ROM_SEQ_CTRL_SYNC_CHECK_EN.
module hp_rom_seq_ctrl import hp_rom_pkg::*; #(
    parameter int WORD_BITS  = DEF_WORD_BITS,
    parameter int SYNC_BITS  = DEF_SYNC_BITS,
    parameter int SYNC_START = DEF_SYNC_START,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int ADDR_START = DEF_ADDR_START,
    parameter int NROMS      = DEF_NROMS
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   sync,
    input  logic                                   ia,
    output logic [$clog2(NROMS)+ADDR_BITS-1:0]     rom_addr,
    input  logic [SYNC_BITS-1:0]                   rom_data,
    output logic                                   is,
    output logic [$clog2(WORD_BITS)-1:0]           bit_cnt,
    output logic                                   locked,
    output logic                                   sync_err
);

    localparam int CNT_W    = $clog2(WORD_BITS);
    localparam int ROM_BITS = $clog2(NROMS);
    localparam int ADDR_END = ADDR_START + ADDR_BITS;
    localparam int EMIT_END = SYNC_START + SYNC_BITS - 1;

    generate
        if (ADDR_START + ADDR_BITS + 2 > SYNC_START) begin : g_bad_addr_window
            $error("hp_rom_seq_ctrl: address window must end at least two bits before SYNC_START");
        end
        if (SYNC_START + SYNC_BITS > WORD_BITS) begin : g_bad_sync_window
            $error("hp_rom_seq_ctrl: sync window does not fit in the word");
        end
        if (SYNC_BITS < 10 || NROMS < 2 || ADDR_BITS < 2) begin : g_bad_widths
            $error("hp_rom_seq_ctrl: need SYNC_BITS >= 10, NROMS >= 2, ADDR_BITS >= 2");
        end
    endgenerate

    logic             w_edge;
    logic             w_lock_nxt;
    logic [CNT_W-1:0] w_bit_cnt;
    logic [CNT_W-1:0] w_bit;
    logic             w_in_addr;
    logic             w_in_emit;

    hp_bit_timer #(
        .WORD_BITS  (WORD_BITS),
        .SYNC_START (SYNC_START)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sync     (sync),
        .o_bit_cnt  (w_bit_cnt),
        .o_edge     (w_edge),
        .o_locked   (locked),
        .o_lock_nxt (w_lock_nxt),
        .o_sync_err (sync_err)
    );

    // The sync edge cycle acts as bit SYNC_START regardless of where the counter was.
    assign w_bit     = w_edge ? CNT_W'(SYNC_START) : w_bit_cnt;
    assign w_in_addr = (w_bit >= CNT_W'(ADDR_START)) && (w_bit < CNT_W'(ADDR_END));
    assign w_in_emit = (w_bit >= CNT_W'(SYNC_START)) && (w_bit <= CNT_W'(EMIT_END));
    assign bit_cnt   = w_bit_cnt;

    logic [ADDR_BITS-1:0]          r_addr_sr;
    logic [ROM_BITS+ADDR_BITS-1:0] r_rom_addr;
    logic [ROM_BITS-1:0]           r_active;
    logic [ROM_BITS-1:0]           r_pending;
    logic [SYNC_BITS-1:0]          r_shift;
    logic [SYNC_BITS-1:0]          r_instr;
    logic                          r_is;

    // An early sync edge jumps the counter past ADDR_END, so a partial capture never reaches rom_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_sr  <= '0;
            r_rom_addr <= '0;
            r_active   <= '0;
            r_pending  <= '0;
            r_shift    <= '0;
            r_instr    <= '0;
            r_is       <= 1'b0;
        end else begin
            if (w_bit == CNT_W'(ADDR_START)) begin
                r_active <= r_pending;
            end
            if (w_in_addr) begin
                r_addr_sr <= {ia, r_addr_sr[ADDR_BITS-1:1]};
            end
            if (w_bit == CNT_W'(ADDR_END)) begin
                r_rom_addr <= {r_active, r_addr_sr};
            end
            if (w_bit == CNT_W'(SYNC_START - 1)) begin
                r_shift <= rom_data;
                r_instr <= rom_data;
            end
            if (w_in_emit) begin
                r_is    <= r_shift[0] & w_lock_nxt;
                r_shift <= r_shift >> 1;
            end else begin
                r_is <= 1'b0;
            end
            if (w_bit == CNT_W'(EMIT_END) && is_sel_rom(r_instr[6:0])) begin
                r_pending <= ROM_BITS'(r_instr[9:7]);
            end
        end
    end

    assign rom_addr = r_rom_addr;
    assign is       = r_is;

endmodule

// File: doc/hp_rom_seq_ctrl.md
# hp_rom_seq_ctrl

Parametrised serial-ROM sequencer for the calculator datapath. It recovers the bit-time phase from `sync` and assembles the serial ROM address from `ia`. It presents a parallel address to the external ROM array and shifts the returned instruction out serially on `is` during the sync window. It also tracks a delayed "select ROM" bank register across `NROMS` ROMs.

## Interface
- `WORD_BITS`, 56: bit-times per word (counter modulus).
- `SYNC_BITS`, 10: instruction width; `sync` high for this many bit-times.
- `SYNC_START`, 44: bit index of first sync-high bit-time.
- `ADDR_BITS`, 8: per-ROM word address width.
- `ADDR_START`, 19: bit index of first `ia` address bit.
- `NROMS`, 8: ROM count; `ROM_BITS = $clog2(NROMS)`.
- `clk` in 1: bit-time clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sync` in 1: word sync.
- `ia` in 1: serial address, LSB first.
- `rom_addr` out ROM_BITS+ADDR_BITS: {active ROM, word address} to the ROM array.
- `rom_data` in SYNC_BITS: instruction from the array, valid one clk after `rom_addr` changes.
- `is` out 1: serial instruction, LSB first.
- `bit_cnt` out $clog2(WORD_BITS): current bit-time index.
- `locked` out 1: phase lock achieved.
- `sync_err` out 1: one-cycle pulse on an unexpected sync edge.

## Operation
- Bit timer: `bit_cnt` increments modulo WORD_BITS. A `sync` rising edge (registered previous `sync` = 0, current = 1) forces the next `bit_cnt` to SYNC_START+1. The edge cycle itself is treated as bit SYNC_START.
- Lock: `locked` sets after two consecutive sync edges, each arriving when `bit_cnt` == SYNC_START. An edge at any other count clears `locked`, pulses `sync_err`, and still forces resync.
- Address capture: while `bit_cnt` is in [ADDR_START, ADDR_START+ADDR_BITS-1], `ia` is shifted into the address register LSB first. At `bit_cnt` == ADDR_START+ADDR_BITS, `rom_addr` updates to {active_rom, captured}.
- Fetch: at `bit_cnt` == SYNC_START-1, `rom_data` is loaded into the SYNC_BITS instruction shift register.
- Emit: during bits SYNC_START..SYNC_START+SYNC_BITS-1, `is` equals shift-register bit 0, and the register shifts right each cycle. Outside the window `is` = 0. Emission is gated by `locked`: if not locked, `is` = 0, but the shift still runs.
- ROM select: the emitted instruction is decoded after its last bit. If instr[6:0] == 7'b0010000, then pending_rom = instr[9:7] (masked to ROM_BITS). pending_rom is copied to active_rom at the next `bit_cnt` == ADDR_START, so the next word's fetch already uses the new bank.
- Parameter legality, checked at elaboration: ADDR_START+ADDR_BITS+2 <= SYNC_START; SYNC_START+SYNC_BITS <= WORD_BITS.

## Timing
- Reset values: `bit_cnt` 0, `locked` 0, `sync_err` 0, `rom_addr` 0, `is` 0, active_rom 0, pending_rom 0, shift registers 0.
- `rom_addr` is registered; it changes one clk after the last address bit.
- `rom_data` is sampled exactly once per word, at SYNC_START-1.
- `is` is registered. It is valid from the clk after the sync rising edge is sampled, for SYNC_BITS cycles.
- Sync edge coinciding with the address window: the address capture is aborted. `rom_addr` keeps its previous value for this word.
- Reset mid-word: all state clears immediately (async). Lock must be re-acquired with two good edges.
- `sync` held high longer than SYNC_BITS: no new edge is generated, so there is no error. Emission still stops after SYNC_BITS bits.

## Configuration
- `HP_ROM_SEQ_CTRL_SYNC_CHECK_EN`:
  - Defined: lock/error logic as above.
  - Undefined: `locked` is tied to 1, `sync_err` is tied to 0, and every sync edge simply forces resync; emission is never gated.

## Structure
- Package `hp_rom_pkg` holds:
  - the default word geometry localparams (56/10/44/19/8);
  - the select-ROM opcode constant `SEL_ROM_OP = 7'b0010000`;
  - the typedef for the {rom, addr} address struct.
- Sub-module `hp_bit_timer` contains the counter, sync edge detect and lock logic. It outputs `bit_cnt`, `locked` and `sync_err`.

## Test plan
- Reset release, then sync edges every 56 clk, each at count 44 → `locked` = 1 after the second edge; `sync_err` never pulses.
- Serial `ia` = 0xA5 during bits 19..26 → `rom_addr` = 0x0A5 at the bit-27 clk edge; `rom_data` = 0x2B3 → `is` emits 1,1,0,0,1,1,0,1,0,1 over bits 44..53.
- Emitted instruction 0x390 (rom 7, select opcode) → the next word's `rom_addr` = {3'd7, addr}. The word carrying the select still uses rom 0.
- Sync edge arriving 3 clk early → `sync_err` pulses for 1 clk, `locked` drops, `is` = 0 for that word; two good words later `locked` = 1 again.
- Assert `rst_n` low at bit 48 mid-emission → `is`, `rom_addr` and `locked` are 0 immediately, with no clk required.
- Build without `HP_ROM_SEQ_CTRL_SYNC_CHECK_EN` and apply a misplaced edge → `sync_err` stays 0, `locked` stays 1, and the counter resyncs to 45 on the next clk.
